// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples sclk/cs_n/mosi in the clk domain, receives a
// 128/192/256-bit frame MSB-first and shifts a response block out on miso.
module spi_slave #(
  parameter int MAX_BITS    = 256,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                cs_n,
  input  logic                mosi,
  output logic                miso,
  input  logic [1:0]          size,
  input  logic [MAX_BITS-1:0] tx_data,
  output logic [MAX_BITS-1:0] rx_data,
  output logic                rx_valid,
  output logic                busy,
  output logic                err
);

  localparam int CW = $clog2(MAX_BITS + 1);
  localparam logic [CW-1:0] MAX_N = CW'(MAX_BITS);
  localparam logic [MAX_BITS-1:0] ONES = {MAX_BITS{1'b1}};

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  logic [SYNC_STAGES-1:0] sclkSync_q, csSync_q, mosiSync_q;
  logic                   sclkDly_q, csDly_q;
  logic                   sclkRise, sclkFall, csRise, csFall, mosiBit;

  state_t                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [CW-1:0]          nBits_q, nBits_d;
  logic [MAX_BITS-1:0]    txShift_q, txShift_d;
  logic [MAX_BITS-1:0]    rxShift_q, rxShift_d;
  logic [MAX_BITS-1:0]    rxData_q, rxData_d;
  logic                   miso_q, miso_d;
  logic                   err_q, err_d;
  logic                   commit_q, commit_d;
  logic                   rxValid_q, rxValid_d;
  logic [CW-1:0]          sizeBits;
  logic [MAX_BITS-1:0]    txLoad;
  logic [MAX_BITS-1:0]    rxMask;

  // cs_n chain resets low so a select held low across reset never looks like a new frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclkSync_q <= '0;
      csSync_q   <= '0;
      mosiSync_q <= '0;
      sclkDly_q  <= 1'b0;
      csDly_q    <= 1'b0;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk};
      csSync_q   <= {csSync_q[SYNC_STAGES-2:0], cs_n};
      mosiSync_q <= {mosiSync_q[SYNC_STAGES-2:0], mosi};
      sclkDly_q  <= sclkSync_q[SYNC_STAGES-1];
      csDly_q    <= csSync_q[SYNC_STAGES-1];
    end
  end

  assign sclkRise = sclkSync_q[SYNC_STAGES-1] & ~sclkDly_q;
  assign sclkFall = ~sclkSync_q[SYNC_STAGES-1] & sclkDly_q;
  assign csRise   = csSync_q[SYNC_STAGES-1] & ~csDly_q;
  assign csFall   = ~csSync_q[SYNC_STAGES-1] & csDly_q;
  assign mosiBit  = mosiSync_q[SYNC_STAGES-1];

  always_comb begin
    case (size)
      2'b00:   sizeBits = CW'(128);
      2'b01:   sizeBits = CW'(192);
      default: sizeBits = CW'(256);
    endcase
  end

  // Response is left-justified so the next miso bit is always the buffer MSB
  assign txLoad = tx_data << (MAX_N - sizeBits);
  assign rxMask = ONES >> (MAX_N - nBits_q);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    nBits_d   = nBits_q;
    txShift_d = txShift_q;
    rxShift_d = rxShift_q;
    rxData_d  = rxData_q;
    miso_d    = miso_q;
    err_d     = 1'b0;
    commit_d  = 1'b0;
    rxValid_d = 1'b0;

    if (commit_q) begin
      rxData_d  = rxShift_q & rxMask;
      rxValid_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        miso_d  = 1'b0;
        count_d = '0;
        if (csFall) begin
          if (size == 2'b11) begin
            err_d   = 1'b1;
            state_d = HOLD;
          end else begin
            nBits_d   = sizeBits;
            txShift_d = txLoad;
            miso_d    = txLoad[MAX_BITS-1];
            state_d   = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (sclkRise) begin
          rxShift_d = {rxShift_q[MAX_BITS-2:0], mosiBit};
          count_d   = (count_q == nBits_q) ? count_q : count_q + CW'(1);
        end
        // Completion wins over a simultaneous deselect
        if (sclkRise && (count_q == nBits_q - CW'(1))) begin
          commit_d = 1'b1;
          miso_d   = 1'b0;
          state_d  = HOLD;
        end else if (csRise) begin
          err_d   = 1'b1;
          miso_d  = 1'b0;
          state_d = IDLE;
        end else if (sclkFall) begin
          txShift_d = txShift_q << 1;
          miso_d    = txShift_q[MAX_BITS-2];
        end
      end
      HOLD: begin
        miso_d = 1'b0;
        if (csRise) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      nBits_q   <= '0;
      txShift_q <= '0;
      rxShift_q <= '0;
      rxData_q  <= '0;
      miso_q    <= 1'b0;
      err_q     <= 1'b0;
      commit_q  <= 1'b0;
      rxValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      nBits_q   <= nBits_d;
      txShift_q <= txShift_d;
      rxShift_q <= rxShift_d;
      rxData_q  <= rxData_d;
      miso_q    <= miso_d;
      err_q     <= err_d;
      commit_q  <= commit_d;
      rxValid_q <= rxValid_d;
    end
  end

  assign miso     = miso_q;
  assign rx_data  = rxData_q;
  assign rx_valid = rxValid_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural SPI master drives frames while
// pulse monitors count rx_valid/err and the miso stream is captured per bit.
module tb_spi_slave;

  logic         clk = 1'b0;
  logic         reset;
  logic         sclk, cs_n, mosi, miso;
  logic [1:0]   size;
  logic [255:0] tx_data, rx_data;
  logic         rx_valid, busy, err;

  int vectors = 0;
  int miscompares = 0;
  int validCount = 0;
  int errCount = 0;
  int v0, e0;
  logic [511:0] misoBits;
  logic [255:0] misoWord;

  localparam logic [255:0] D128 = 256'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [255:0] TX1  = {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, {16{8'hA5}}};
  localparam logic [255:0] D256 = 256'h01234567_89ABCDEF_FEDCBA98_76543210_DEADBEEF_CAFEF00D_11223344_55667788;
  localparam logic [255:0] TX256 = {8{32'h3C5A_96E1}};
  localparam logic [255:0] D192 = {64'h0, 192'hC001D00D_12345678_9ABCDEF0_0FEDCBA9_87654321_55AA33CC};
  localparam logic [255:0] TX192 = {64'hFFFF_FFFF_FFFF_FFFF, 192'h13579BDF_2468ACE0_F0E1D2C3_B4A59687_78695A4B_3C2D1E0F};
  localparam logic [255:0] D4   = 256'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  localparam logic [255:0] TX4  = 256'h1;
  localparam logic [255:0] D6   = 256'h55555555_AAAAAAAA_33333333_CCCCCCCC;
  localparam logic [255:0] TX6  = {128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 128'h01234567_89ABCDEF_0F0F0F0F_F0F0F0F0};

  spi_slave #(.MAX_BITS(256), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .size(size), .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) validCount++;
    if (err === 1'b1) errCount++;
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic startFrame();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic clockBit(input int idx, input logic b);
    mosi = b;
    repeat (4) @(negedge clk);
    misoBits[idx] = miso;
    sclk = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic endFrame();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic getMiso(input int n);
    misoWord = '0;
    for (int i = 0; i < n; i++) misoWord[n-1-i] = misoBits[i];
  endtask

  // Bits beyond nBits drive mosi high; size/tx_data are scrambled mid-frame
  task automatic applyStimulus(input logic [1:0] sz, input logic [255:0] tx,
                               input logic [255:0] data, input int nBits, input int total);
    size = sz;
    tx_data = tx;
    misoBits = '0;
    startFrame();
    size = 2'b11;
    tx_data = ~tx;
    for (int i = 0; i < total; i++) clockBit(i, (i < nBits) ? data[nBits-1-i] : 1'b1);
    endFrame();
  endtask

  initial begin
    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; size = 2'b00; tx_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rx_data", rx_data, 256'h0);
    checkOutput("reset_rx_valid", 256'(rx_valid), 256'h0);
    checkOutput("reset_err", 256'(err), 256'h0);
    checkOutput("reset_busy", 256'(busy), 256'h0);
    checkOutput("reset_miso", 256'(miso), 256'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] test 1: 128-bit frame");
    v0 = validCount; e0 = errCount;
    applyStimulus(2'b00, TX1, D128, 128, 128);
    getMiso(128);
    checkOutput("t1_rx_data", rx_data, D128);
    checkOutput("t1_miso", misoWord, {128'h0, {16{8'hA5}}});
    checkOutput("t1_valid_pulses", 256'(validCount - v0), 256'd1);
    checkOutput("t1_err_pulses", 256'(errCount - e0), 256'd0);
    checkOutput("t1_busy_idle", 256'(busy), 256'h0);

    $display("[TB] test 2: 256-bit then 192-bit frame");
    v0 = validCount; e0 = errCount;
    applyStimulus(2'b10, TX256, D256, 256, 256);
    getMiso(256);
    checkOutput("t2_rx_data_256", rx_data, D256);
    checkOutput("t2_miso_256", misoWord, TX256);
    applyStimulus(2'b01, TX192, D192, 192, 192);
    getMiso(192);
    checkOutput("t2_rx_data_192", rx_data, D192);
    checkOutput("t2_miso_192", misoWord, {64'h0, TX192[191:0]});
    checkOutput("t2_valid_pulses", 256'(validCount - v0), 256'd2);
    checkOutput("t2_err_pulses", 256'(errCount - e0), 256'd0);

    $display("[TB] test 3: abort after 100 bits");
    v0 = validCount; e0 = errCount;
    applyStimulus(2'b00, TX1, D4, 128, 100);
    checkOutput("t3_err_pulses", 256'(errCount - e0), 256'd1);
    checkOutput("t3_valid_pulses", 256'(validCount - v0), 256'd0);
    checkOutput("t3_rx_data_kept", rx_data, D192);
    checkOutput("t3_busy_idle", 256'(busy), 256'h0);

    $display("[TB] test 4: 136 sclk cycles on a 128-bit frame");
    v0 = validCount; e0 = errCount;
    applyStimulus(2'b00, TX4, D4, 128, 136);
    getMiso(128);
    checkOutput("t4_rx_data", rx_data, D4);
    checkOutput("t4_miso", misoWord, 256'h1);
    checkOutput("t4_miso_extra", 256'(misoBits[135:128]), 256'h0);
    checkOutput("t4_valid_pulses", 256'(validCount - v0), 256'd1);
    checkOutput("t4_err_pulses", 256'(errCount - e0), 256'd0);

    $display("[TB] test 5: illegal size");
    v0 = validCount; e0 = errCount;
    size = 2'b11; tx_data = TX1; misoBits = '0;
    startFrame();
    checkOutput("t5_err_at_start", 256'(errCount - e0), 256'd1);
    checkOutput("t5_busy_hold", 256'(busy), 256'h1);
    for (int i = 0; i < 8; i++) clockBit(i, 1'b1);
    endFrame();
    checkOutput("t5_miso", 256'(misoBits[7:0]), 256'h0);
    checkOutput("t5_valid_pulses", 256'(validCount - v0), 256'd0);
    checkOutput("t5_err_total", 256'(errCount - e0), 256'd1);
    checkOutput("t5_busy_idle", 256'(busy), 256'h0);
    checkOutput("t5_rx_data_kept", rx_data, D4);

    $display("[TB] test 6: reset mid-frame");
    size = 2'b10; tx_data = TX256;
    startFrame();
    for (int i = 0; i < 64; i++) clockBit(i, D256[255-i]);
    checkOutput("t6_busy_before", 256'(busy), 256'h1);
    #3 reset = 1'b1;
    #1;
    checkOutput("t6_async_rx_data", rx_data, 256'h0);
    checkOutput("t6_async_rx_valid", 256'(rx_valid), 256'h0);
    checkOutput("t6_async_err", 256'(err), 256'h0);
    checkOutput("t6_async_busy", 256'(busy), 256'h0);
    checkOutput("t6_async_miso", 256'(miso), 256'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t6_no_false_start", 256'(busy), 256'h0);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    v0 = validCount; e0 = errCount;
    applyStimulus(2'b00, TX6, D6, 128, 128);
    getMiso(128);
    checkOutput("t6_rx_data", rx_data, D6);
    checkOutput("t6_miso", misoWord, {128'h0, TX6[127:0]});
    checkOutput("t6_valid_pulses", 256'(validCount - v0), 256'd1);
    checkOutput("t6_err_pulses", 256'(errCount - e0), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
